// File: rtl/eth_fcs_pkg.sv
// Shared types, CRC constants and the word-serial CRC-32 step for the TX framer.
package eth_fcs_pkg;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    DROP,
    FCS
  } fcs_state_e;

  // One outbound word as it travels through the output register.
  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } fcs_word_t;

  // Folds one 32-bit word into the running CRC, MSB first, no reflection.
  function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] x;
    x = c ^ d;
    for (int i = 0; i < 32; i++)
      x = x[31] ? ((x << 1) ^ CRC32_POLY) : (x << 1);
    return x;
  endfunction

endpackage

// File: rtl/eth_tx_out_reg.sv
// Single-stage valid/ready output register; loads whenever empty or drained.
module eth_tx_out_reg
  import eth_fcs_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  input  fcs_word_t in_word,
  input  logic      m_ready,
  output logic      adv,
  output logic      m_valid,
  output fcs_word_t m_word
);

  assign adv = !m_valid || m_ready;

  // Payload only changes on a real load so an idle bus keeps its last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_word  <= '0;
    end else if (adv) begin
      m_valid <= in_valid;
      if (in_valid) m_word <= in_word;
    end
  end

endmodule

// File: rtl/eth_tx_fcs_framer.sv
// TX framing stage: passes payload words, zero-pads short frames,
// truncates long ones and appends the inverted CRC-32 as the FCS word.
module eth_tx_fcs_framer
  import eth_fcs_pkg::*;
#(
  parameter int MIN_WORDS = 15,
  parameter int MAX_WORDS = 379,
  parameter int CNT_W     = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        err_oversize,
  output logic [15:0] frames_sent
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WORDS);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WORDS);

  fcs_state_e       state, state_n;
  logic [31:0]      crc, crc_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             adv, accept, err_n;
  logic             o_valid;
  fcs_word_t        o_word, m_word;
  logic [15:0]      frames_q;

  assign cnt_inc = cnt + 1'b1;

  // DROP swallows input regardless of the output stage; otherwise input
  // is only taken when the output register can load this cycle.
  assign s_ready = !rst && ((adv && (state == IDLE || state == DATA)) || state == DROP);
  assign accept  = s_valid && s_ready;

  // State, CRC and word counter advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      crc          <= CRC32_INIT;
      cnt          <= '0;
      err_oversize <= 1'b0;
    end else begin
      state        <= state_n;
      crc          <= crc_n;
      cnt          <= cnt_n;
      err_oversize <= err_n;
    end
  end

  // Next-state, CRC update and the word offered to the output register.
  always_comb begin
    state_n = state;
    crc_n   = crc;
    cnt_n   = cnt;
    err_n   = 1'b0;
    o_valid = 1'b0;
    o_word  = '0;
    unique case (state)
      IDLE: if (accept) begin
        o_valid     = 1'b1;
        o_word.data = s_data;
        crc_n       = crc32_step(CRC32_INIT, s_data);
        cnt_n       = CNT_W'(1);
        if (s_last) state_n = (MIN_WORDS > 1) ? PAD : FCS;
        else        state_n = DATA;
      end
      DATA: if (accept) begin
        o_valid     = 1'b1;
        o_word.data = s_data;
        crc_n       = crc32_step(crc, s_data);
        cnt_n       = cnt_inc;
        if (s_last) begin
          state_n = (cnt_inc < MIN_C) ? PAD : FCS;
        end else if (cnt_inc == MAX_C) begin
          state_n = DROP;
          err_n   = 1'b1;
        end
      end
      PAD: if (adv) begin
        o_valid = 1'b1;
        crc_n   = crc32_step(crc, 32'h0);
        cnt_n   = cnt_inc;
        if (cnt_inc == MIN_C) state_n = FCS;
      end
      DROP: if (accept && s_last) state_n = FCS;
      FCS: if (adv) begin
        o_valid     = 1'b1;
        o_word.data = ~crc;
        o_word.last = 1'b1;
        crc_n       = CRC32_INIT;
        cnt_n       = '0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  eth_tx_out_reg u_out (
    .clk      (clk),
    .rst      (rst),
    .in_valid (o_valid),
    .in_word  (o_word),
    .m_ready  (m_ready),
    .adv      (adv),
    .m_valid  (m_valid),
    .m_word   (m_word)
  );

  assign m_data = m_word.data;
  assign m_last = m_word.last;

  // Frame counter bumps on the FCS handshake and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)                            frames_q <= '0;
    else if (m_valid && m_ready && m_last) frames_q <= frames_q + 16'd1;
  end

  assign frames_sent = frames_q;

endmodule
